// File: rtl/serial_mag_comparator.sv
// rtl/serial_mag_comparator.sv - MSB-first bit-serial unsigned magnitude comparator
//
// Captures a/b on an accepted start, scans one bit pair per clock from the MSB
// and reports the first differing bit as the verdict on registered g/l/e flags.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - compare request, sampled only while idle
//   a, b   - WIDTH-bit unsigned operands, captured on the accept edge
//   busy   - high while scanning or presenting the result
//   done   - one-cycle pulse, result flags valid
//   g/l/e  - a > b / a < b / a == b, held until the next accepted start

module serial_mag_comparator #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             l,
    output logic             e
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    cnt;

    // The verdict is tracked internally while scanning so that the visible
    // flags stay at zero until the result is final.
    logic gt_seen;
    logic lt_seen;

    logic msb_a;
    logic msb_b;
    logic undecided;
    logic gt_next;
    logic lt_next;

    always_comb begin
        msb_a     = sa[WIDTH-1];
        msb_b     = sb[WIDTH-1];
        undecided = !gt_seen && !lt_seen;
        // Only the first differing bit may set a verdict; later bits are ignored.
        gt_next   = gt_seen | (undecided & msb_a & ~msb_b);
        lt_next   = lt_seen | (undecided & ~msb_a & msb_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sa      <= '0;
            sb      <= '0;
            cnt     <= '0;
            gt_seen <= 1'b0;
            lt_seen <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            g       <= 1'b0;
            l       <= 1'b0;
            e       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa      <= a;
                        sb      <= b;
                        cnt     <= CNT_LAST;
                        gt_seen <= 1'b0;
                        lt_seen <= 1'b0;
                        g       <= 1'b0;
                        l       <= 1'b0;
                        e       <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    sa      <= sa << 1;
                    sb      <= sb << 1;
                    gt_seen <= gt_next;
                    lt_seen <= lt_next;
                    if ((EARLY_EXIT && (gt_next || lt_next)) || (cnt == '0)) begin
                        g     <= gt_next;
                        l     <= lt_next;
                        e     <= !(gt_next || lt_next);
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb/tb_serial_mag_comparator.sv - scoreboard bench for serial_mag_comparator

module tb_serial_mag_comparator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_v [3];
    logic [7:0] a_v [3];
    logic [7:0] b_v [3];
    logic       busy_v [3];
    logic       done_v [3];
    logic       g_v [3];
    logic       l_v [3];
    logic       e_v [3];

    int tests_run = 0;
    int tests_failed = 0;

    // Expected outcome of one compare: which DUT, flags {g,l,e}, and latency
    // in edges with the accept edge counted as the first.
    typedef struct {
        int         id;
        logic [2:0] gle;
        int         lat;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    // id 0: WIDTH=8 fixed latency, id 1: WIDTH=8 early exit, id 2: WIDTH=1
    serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_fix (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .g(g_v[0]), .l(l_v[0]), .e(e_v[0])
    );

    serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_early (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .g(g_v[1]), .l(l_v[1]), .e(e_v[1])
    );

    serial_mag_comparator #(.WIDTH(1), .EARLY_EXIT(1'b0)) u_one (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2][0:0]), .b(b_v[2][0:0]),
        .busy(busy_v[2]), .done(done_v[2]), .g(g_v[2]), .l(l_v[2]), .e(e_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dut_width(input int id);
        return (id == 2) ? 1 : 8;
    endfunction

    function automatic exp_t model(input int id, input logic [7:0] av, input logic [7:0] bv);
        exp_t r;
        int   w;
        w     = dut_width(id);
        r.id  = id;
        r.lat = w + 1;
        if (w == 1) begin
            av = av & 8'h01;
            bv = bv & 8'h01;
        end
        r.gle = {av > bv, av < bv, av == bv};
        if (id == 1) begin
            for (int i = w - 1; i >= 0; i--) begin
                if (av[i] != bv[i]) begin
                    r.lat = (w - i) + 1;
                    break;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] flags(input int id);
        return {g_v[id], l_v[id], e_v[id]};
    endfunction

    task automatic run_cmp(input int id, input logic [7:0] av, input logic [7:0] bv,
                           input bit repulse);
        exp_t x;
        int   n;
        bit   got;
        sb_q.push_back(model(id, av, bv));
        @(negedge clk);
        start_v[id] = 1'b1;
        a_v[id]     = av;
        b_v[id]     = bv;
        @(posedge clk);
        #1;
        start_v[id] = 1'b0;
        a_v[id]     = ~av;
        b_v[id]     = ~bv;
        n   = 1;
        got = 1'b0;
        while (!got && n < 40) begin
            if (repulse && n == 3) begin
                start_v[id] = 1'b1;
                a_v[id]     = bv;
                b_v[id]     = av;
            end
            @(posedge clk);
            n++;
            #1;
            if (repulse && n == 4) start_v[id] = 1'b0;
            @(negedge clk);
            if (done_v[id]) got = 1'b1;
            else if (n == 2) begin
                check($sformatf("busy_in_shift[%0d]", id), busy_v[id], 1);
                check($sformatf("flags_zero_in_shift[%0d]", id), flags(id), 0);
            end
        end
        x = sb_q.pop_front();
        check($sformatf("done_seen[%0d] %h/%h", id, av, bv), got, 1);
        check($sformatf("latency[%0d] %h/%h", id, av, bv), n, x.lat);
        check($sformatf("gle[%0d] %h/%h", id, av, bv), flags(id), x.gle);
        check($sformatf("busy_at_done[%0d]", id), busy_v[id], 1);
        @(negedge clk);
        check($sformatf("done_drop[%0d]", id), done_v[id], 0);
        check($sformatf("busy_drop[%0d]", id), busy_v[id], 0);
        check($sformatf("gle_held[%0d] %h/%h", id, av, bv), flags(id), x.gle);
        if (repulse) begin
            int extra;
            extra = 0;
            repeat (12) begin
                @(negedge clk);
                if (done_v[id]) extra++;
            end
            check($sformatf("single_done[%0d]", id), extra, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            a_v[i]     = '0;
            b_v[i]     = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_busy[%0d]", i), busy_v[i], 0);
            check($sformatf("reset_done[%0d]", i), done_v[i], 0);
            check($sformatf("reset_gle[%0d]", i), flags(i), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // fixed latency, WIDTH=8
        run_cmp(0, 8'hA5, 8'hA5, 1'b0);
        run_cmp(0, 8'h80, 8'h7F, 1'b0);
        run_cmp(0, 8'h01, 8'h02, 1'b0);
        run_cmp(0, 8'hFF, 8'h00, 1'b0);
        // start re-pulsed mid-scan with swapped operands must be ignored
        run_cmp(0, 8'h5A, 8'h3C, 1'b1);

        // early exit, WIDTH=8
        run_cmp(1, 8'h00, 8'hFF, 1'b0);
        run_cmp(1, 8'h3C, 8'h3D, 1'b0);
        run_cmp(1, 8'h77, 8'h77, 1'b0);
        run_cmp(1, 8'h48, 8'h40, 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_cmp(1, ra, rb, 1'b0);
            run_cmp(0, ra, rb, 1'b0);
        end

        // WIDTH=1 exhaustive
        run_cmp(2, 8'h00, 8'h00, 1'b0);
        run_cmp(2, 8'h00, 8'h01, 1'b0);
        run_cmp(2, 8'h01, 8'h00, 1'b0);
        run_cmp(2, 8'h01, 8'h01, 1'b0);

        // asynchronous reset in the middle of a scan
        @(negedge clk);
        start_v[0] = 1'b1;
        a_v[0]     = 8'hC3;
        b_v[0]     = 8'hC3;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_before_reset", busy_v[0], 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy_v[0], 0);
        check("abort_done", done_v[0], 0);
        check("abort_gle", flags(0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmp(0, 8'h10, 8'h20, 1'b0);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
